// File: rtl/mem_access_stage_if.sv
// EX/MEM request bundle and MEM-stage response for the data access unit.
// Master drives requests and branch inputs; slave returns load data and status.
interface mem_access_stage_if;
  logic        req_valid;
  logic [31:0] addr_in;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic        zero;
  logic        branch_in;
  logic        branchNot_in;
  logic [31:0] data_out;
  logic        ack_out;
  logic        stall_out;
  logic        misalign_err;
  logic        pcSrc_out;

  modport master (
    output req_valid, addr_in, write_data,
    output mem_read, mem_write, size_in,
    output unsigned_in, zero,
    output branch_in, branchNot_in,
    input  data_out, ack_out, stall_out,
    input  misalign_err, pcSrc_out
  );

  modport slave (
    input  req_valid, addr_in, write_data,
    input  mem_read, mem_write, size_in,
    input  unsigned_in, zero,
    input  branch_in, branchNot_in,
    output data_out, ack_out, stall_out,
    output misalign_err, pcSrc_out
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data access: word RAM, byte/half/word loads and stores,
// fixed access latency with stall handshake, misalign flag, branch resolve.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic reset_n,
  mem_access_stage_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            size;
    logic                  uns;
    logic                  store;
  } req_t;

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic ack_q, ack_d;
  logic mis_q, mis_d;

  logic access, aligned, accept;
  logic is_byte, is_half;
  logic ld_byte, ld_half;
  logic stall, we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata, ext, wlane;
  logic [3:0]  be;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic unused_addr;

  assign unused_addr = ^bus.addr_in[31:IDX_W+2];

  assign access  = bus.req_valid
                 & (bus.mem_read | bus.mem_write);
  assign is_byte = bus.size_in == 2'b00;
  assign is_half = bus.size_in == 2'b01;

  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      is_byte: aligned = 1'b1;
      is_half: aligned = ~bus.addr_in[0];
      default: aligned = bus.addr_in[1:0] == 2'b00;
    endcase
  end

  assign accept = access & aligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter reaching zero on this edge moves us into DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    we    = 1'b0;
    unique case (state_q)
      IDLE: stall = accept;
      BUSY: stall = 1'b1;
      DONE: begin
        stall = ~ack_q;
        we    = req_q.store;
      end
      default: stall = 1'b0;
    endcase
  end

  assign rdata   = mem[req_q.idx];
  assign rbyte   = rdata[{req_q.off, 3'b000} +: 8];
  assign rhalf   = req_q.off[1] ? rdata[31:16]
                                : rdata[15:0];
  assign ld_byte = req_q.size == 2'b00;
  assign ld_half = req_q.size == 2'b01;

  always_comb begin
    ext = rdata;
    unique case (1'b1)
      ld_byte: ext = {{24{~req_q.uns & rbyte[7]}}, rbyte};
      ld_half: ext = {{16{~req_q.uns & rhalf[15]}}, rhalf};
      default: ext = rdata;
    endcase
  end

  always_comb begin
    be    = 4'hF;
    wlane = req_q.wdata;
    unique case (1'b1)
      ld_byte: begin
        be    = 4'b0001 << req_q.off;
        wlane = {4{req_q.wdata[7:0]}};
      end
      ld_half: begin
        be    = req_q.off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wlane = req_q.wdata;
      end
    endcase
  end

  always_comb begin
    req_d  = req_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ack_d  = 1'b0;
    mis_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mis_d = access & ~aligned;
        if (accept) begin
          req_d.idx   = bus.addr_in[IDX_W+1:2];
          req_d.off   = bus.addr_in[1:0];
          req_d.wdata = bus.write_data;
          req_d.size  = bus.size_in;
          req_d.uns   = bus.unsigned_in;
          req_d.store = bus.mem_write;
          cnt_d       = CNT_INIT;
        end
      end
      BUSY: cnt_d = cnt_q - 4'd1;
      DONE: begin
        ack_d = 1'b1;
        if (!req_q.store) begin
          dout_d = ext;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= '0;
      cnt_q  <= 4'd0;
      dout_q <= '0;
      ack_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ack_q  <= ack_d;
      mis_q  <= mis_d;
    end
  end

  // RAM contents survive reset; writes only land in DONE.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[req_q.idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.ack_out      = ack_q;
  assign bus.stall_out    = stall;
  assign bus.misalign_err = mis_q;
  assign bus.pcSrc_out    = (bus.branch_in & bus.zero)
                          | (bus.branchNot_in & ~bus.zero);
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage at LATENCY 1, 2 and 5 against a
// byte-array memory model with random and directed accesses.
module tb_mem_access_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  rv;
  logic [31:0] addr, wd;
  logic        rd, wr, uns, zero, br, bn;
  logic [1:0]  sz;

  logic [31:0] dout_w [3];
  logic [2:0]  ack_w, stall_w, mis_w, pc_w;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_b [3][1024];
  logic [31:0] exp_dout [3];

  for (genvar i = 0; i < 3; i++) begin : g
    mem_access_stage_if bus ();
    assign bus.req_valid    = rv[i];
    assign bus.addr_in      = addr;
    assign bus.write_data   = wd;
    assign bus.mem_read     = rd;
    assign bus.mem_write    = wr;
    assign bus.size_in      = sz;
    assign bus.unsigned_in  = uns;
    assign bus.zero         = zero;
    assign bus.branch_in    = br;
    assign bus.branchNot_in = bn;
    assign dout_w[i]  = bus.data_out;
    assign ack_w[i]   = bus.ack_out;
    assign stall_w[i] = bus.stall_out;
    assign mis_w[i]   = bus.misalign_err;
    assign pc_w[i]    = bus.pcSrc_out;
    mem_access_stage #(
      .DATA_WIDTH(32),
      .MEM_DEPTH (256),
      .LATENCY   (i == 0 ? 1 : (i == 1 ? 2 : 5))
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
  end

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 5);
  endfunction

  function automatic int nbytes(logic [1:0] z);
    return (z == 2'd0) ? 1 : ((z == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic m_aligned(logic [31:0] a, logic [1:0] z);
    return (int'(a[1:0]) % nbytes(z)) == 0;
  endfunction

  function automatic void m_store(int s, logic [31:0] a,
                                  logic [1:0] z, logic [31:0] d);
    int n = nbytes(z);
    for (int j = 0; j < n; j++)
      ref_b[s][(int'(a[9:0]) + j) % 1024] = d[8*j +: 8];
  endfunction

  function automatic logic [31:0] m_load(int s, logic [31:0] a,
                                         logic [1:0] z, logic u);
    logic [31:0] v = 32'd0;
    int n = nbytes(z);
    for (int j = 0; j < n; j++)
      v[8*j +: 8] = ref_b[s][(int'(a[9:0]) + j) % 1024];
    if (n < 4 && !u && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Drives one request to instance s and observes its response.
  // lat: edges from acceptance to ack (-1 = none); stc: stalled cycles after acceptance.
  task automatic access(input int s, input logic r, input logic w,
                        input logic [1:0] z, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int stc,
                        output int mis, output logic pre);
    int lim = lat_of(s) + 4;
    @(negedge clk);
    rd = r; wr = w; sz = z; uns = u; addr = a; wd = d;
    rv = '0; rv[s] = 1'b1;
    #1;
    pre = stall_w[s];
    lat = -1; stc = 0; mis = 0;
    @(posedge clk); #1;
    rv = '0; rd = 1'b0; wr = 1'b0;
    if (mis_w[s]) mis++;
    if (stall_w[s]) stc++;
    for (int k = 1; k <= lim && lat < 0; k++) begin
      @(posedge clk); #1;
      if (mis_w[s]) mis++;
      if (ack_w[s]) lat = k;
      else if (stall_w[s]) stc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rv = '0; rd = 0; wr = 0;
    addr = 0; wd = 0; sz = 0; uns = 0;
    zero = 0; br = 0; bn = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (dout_w[s] !== 32'd0) begin
        bad++; $display("FAIL reset_dout s=%0d got=%0h want=0", s, dout_w[s]);
      end
      total++;
      if ({ack_w[s], stall_w[s], mis_w[s]} !== 3'b000) begin
        bad++;
        $display("FAIL reset_flags s=%0d got=%b want=000", s,
                 {ack_w[s], stall_w[s], mis_w[s]});
      end
      exp_dout[s] = 32'd0;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_word(int s);
    int lat, stc, mis;
    logic pre;
    int L = lat_of(s);
    access(s, 0, 1, 2'd2, 0, 32'd0, 32'hDEADBEEF, lat, stc, mis, pre);
    m_store(s, 32'd0, 2'd2, 32'hDEADBEEF);
    total++;
    if (lat !== L || stc !== L || pre !== 1'b1) begin
      bad++;
      $display("FAIL sw_timing s=%0d got lat=%0d stall=%0d pre=%b want %0d/%0d/1",
               s, lat, stc, pre, L, L);
    end
    total++;
    if (dout_w[s] !== exp_dout[s]) begin
      bad++; $display("FAIL sw_dout s=%0d got=%0h want=%0h", s, dout_w[s], exp_dout[s]);
    end
    access(s, 1, 0, 2'd2, 0, 32'd0, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = 32'hDEADBEEF;
    total++;
    if (lat !== L || stc !== L || dout_w[s] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw s=%0d got lat=%0d stall=%0d data=%0h want %0d/%0d/deadbeef",
               s, lat, stc, dout_w[s], L, L);
    end
  endtask

  task automatic test_subword(int s);
    int lat, stc, mis;
    logic pre;
    logic [1:0]  tz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        tu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ta [4] = '{32'd1, 32'd1, 32'd2, 32'd2};
    logic [31:0] te [4] = '{32'hFFFFFFBE, 32'h000000BE,
                            32'hFFFFDEAD, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      access(s, 1, 0, tz[i], tu[i], ta[i], 32'd0, lat, stc, mis, pre);
      exp_dout[s] = te[i];
      total++;
      if (dout_w[s] !== te[i] || lat !== lat_of(s)) begin
        bad++;
        $display("FAIL subload%0d s=%0d got=%0h lat=%0d want=%0h", i, s,
                 dout_w[s], lat, te[i]);
      end
    end
    access(s, 0, 1, 2'd0, 0, 32'd3, 32'hFFFF_FF11, lat, stc, mis, pre);
    m_store(s, 32'd3, 2'd0, 32'hFFFF_FF11);
    access(s, 1, 0, 2'd2, 0, 32'd0, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = 32'h11ADBEEF;
    total++;
    if (dout_w[s] !== 32'h11ADBEEF) begin
      bad++; $display("FAIL sb_lw s=%0d got=%0h want=11adbeef", s, dout_w[s]);
    end
  endtask

  task automatic test_misalign(int s);
    int lat, stc, mis;
    logic pre;
    logic        tr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  tz [4] = '{2'd2, 2'd1, 2'd2, 2'd1};
    logic [31:0] ta [4] = '{32'd2, 32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 4; i++) begin
      access(s, tr[i], ~tr[i], tz[i], 0, ta[i], 32'h0, lat, stc, mis, pre);
      total++;
      if (mis !== 1 || lat !== -1 || stc !== 0 || pre !== 1'b0
          || dout_w[s] !== exp_dout[s]) begin
        bad++;
        $display("FAIL misalign%0d s=%0d got mis=%0d lat=%0d stall=%0d data=%0h want 1/-1/0 %0h",
                 i, s, mis, lat, stc, dout_w[s], exp_dout[s]);
      end
    end
    access(s, 0, 0, 2'd2, 0, 32'd0, 32'h0, lat, stc, mis, pre);
    total++;
    if (mis !== 0 || lat !== -1 || stc !== 0 || pre !== 1'b0) begin
      bad++;
      $display("FAIL noop s=%0d got mis=%0d lat=%0d stall=%0d want 0/-1/0",
               s, mis, lat, stc);
    end
    access(s, 1, 0, 2'd2, 0, 32'd0, 32'h0, lat, stc, mis, pre);
    exp_dout[s] = m_load(s, 32'd0, 2'd2, 0);
    total++;
    if (dout_w[s] !== exp_dout[s]) begin
      bad++;
      $display("FAIL misalign_ram s=%0d got=%0h want=%0h", s, dout_w[s], exp_dout[s]);
    end
  endtask

  task automatic test_back_to_back(int s);
    int lat, stc, mis;
    logic pre;
    logic [31:0] d = $urandom;
    access(s, 0, 1, 2'd2, 0, 32'd8, d, lat, stc, mis, pre);
    m_store(s, 32'd8, 2'd2, d);
    access(s, 1, 0, 2'd2, 0, 32'd8, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = d;
    total++;
    if (lat !== lat_of(s) || pre !== 1'b1 || dout_w[s] !== d) begin
      bad++;
      $display("FAIL b2b s=%0d got lat=%0d pre=%b data=%0h want %0d/1/%0h",
               s, lat, pre, dout_w[s], lat_of(s), d);
    end
  endtask

  task automatic test_wrap(int s);
    int lat, stc, mis;
    logic pre;
    access(s, 0, 1, 2'd2, 0, 32'd1024, 32'hCAFEF00D, lat, stc, mis, pre);
    m_store(s, 32'd1024, 2'd2, 32'hCAFEF00D);
    access(s, 1, 0, 2'd2, 0, 32'd0, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = 32'hCAFEF00D;
    total++;
    if (dout_w[s] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL wrap s=%0d got=%0h want=cafef00d", s, dout_w[s]);
    end
    access(s, 1, 0, 2'd1, 1, 32'hFFFF_FC02, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = 32'h0000CAFE;
    total++;
    if (dout_w[s] !== 32'h0000CAFE) begin
      bad++; $display("FAIL wrap_hi s=%0d got=%0h want=0000cafe", s, dout_w[s]);
    end
  endtask

  task automatic test_random(int s, int n);
    int lat, stc, mis;
    int el, es, em;
    logic pre, ep, r, w, u, acc;
    logic [1:0]  z;
    logic [31:0] a, d;
    int L = lat_of(s);
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      access(s, 0, 1, 2'd2, 0, 32'(4*i), d, lat, stc, mis, pre);
      m_store(s, 32'(4*i), 2'd2, d);
    end
    for (int i = 0; i < n; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      z = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      d = $urandom;
      access(s, r, w, z, u, a, d, lat, stc, mis, pre);
      acc = r | w;
      if (acc && m_aligned(a, z)) begin
        el = L; es = L; em = 0; ep = 1'b1;
        if (w) m_store(s, a, z, d);
        else exp_dout[s] = m_load(s, a, z, u);
      end else begin
        el = -1; es = 0; em = acc ? 1 : 0; ep = 1'b0;
      end
      total++;
      if (lat !== el || stc !== es || mis !== em || pre !== ep
          || dout_w[s] !== exp_dout[s]) begin
        bad++;
        $display("FAIL rand s=%0d i=%0d op=%b%b sz=%0d a=%0h got lat=%0d st=%0d mis=%0d pre=%b d=%0h want %0d/%0d/%0d/%b/%0h",
                 s, i, r, w, z, a, lat, stc, mis, pre, dout_w[s],
                 el, es, em, ep, exp_dout[s]);
      end
    end
  endtask

  task automatic test_branch();
    logic e;
    int k;
    for (int c = 0; c < 8; c++) begin
      {br, bn, zero} = 3'(c);
      #1;
      e = (br && zero) || (bn && !zero);
      total++;
      if (pc_w[1] !== e) begin
        bad++; $display("FAIL pcsrc c=%0d got=%b want=%b", c, pc_w[1], e);
      end
    end
    @(negedge clk);
    rd = 1; wr = 0; sz = 2'd2; addr = 32'd0; rv = 3'b100;
    @(posedge clk); #1;
    rv = '0; rd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      {br, bn, zero} = (c < 2) ? {2'b10, 1'(c)} : {2'b01, 1'(c - 2)};
      #1;
      e = (c == 1) || (c == 2);
      total++;
      if (pc_w[2] !== e || stall_w[2] !== 1'b1) begin
        bad++;
        $display("FAIL pcsrc_stall c=%0d got pc=%b stall=%b want %b/1", c,
                 pc_w[2], stall_w[2], e);
      end
    end
    k = 0;
    while (ack_w[2] !== 1'b1 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    total++;
    if (ack_w[2] !== 1'b1) begin
      bad++; $display("FAIL pcsrc_ack got=%b want=1", ack_w[2]);
    end
    exp_dout[2] = m_load(2, 32'd0, 2'd2, 0);
    br = 0; bn = 0; zero = 0;
  endtask

  task automatic test_reset_mid_store(int s);
    int lat, stc, mis;
    logic pre;
    int acks = 0;
    access(s, 0, 1, 2'd2, 0, 32'd4, 32'h12345678, lat, stc, mis, pre);
    m_store(s, 32'd4, 2'd2, 32'h12345678);
    @(negedge clk);
    wr = 1; sz = 2'd2; addr = 32'd4; wd = 32'd7; rv = '0; rv[s] = 1'b1;
    @(posedge clk); #1;
    rv = '0; wr = 0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (dout_w[s] !== 32'd0 || stall_w[s] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid s=%0d got data=%0h stall=%b want 0/0", s,
               dout_w[s], stall_w[s]);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack_w[s]) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL rst_mid_ack s=%0d got=%0d want=0", s, acks);
    end
    for (int i = 0; i < 3; i++) exp_dout[i] = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    access(s, 1, 0, 2'd2, 0, 32'd4, 32'd0, lat, stc, mis, pre);
    exp_dout[s] = 32'h12345678;
    total++;
    if (dout_w[s] !== 32'h12345678 || lat !== lat_of(s)) begin
      bad++;
      $display("FAIL rst_mid_lw s=%0d got=%0h lat=%0d want=12345678", s,
               dout_w[s], lat);
    end
  endtask

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      test_word(s);
      test_subword(s);
      test_misalign(s);
      test_back_to_back(s);
      test_wrap(s);
      test_random(s, 60);
    end
    test_branch();
    for (int s = 0; s < 3; s++) test_reset_mid_store(s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
